// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: opcode constants, the NOP encoding and the fetch FSM states.
// The HALT state exists only when IF_ALIGN_CHECK_EN is defined.
package riscv_pkg;

  localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
  localparam logic [6:0]  OPC_STORE = 7'b0100011;
  localparam logic [6:0]  OPC_OPIMM = 7'b0010011;
  localparam logic [6:0]  OPC_OP    = 7'b0110011;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
`ifdef IF_ALIGN_CHECK_EN
    ,
    S_HALT  = 2'd3
`endif
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack, decode valid/ready and the redirect port.
// The master modport is the fetch unit; the slave modport is the memory/decode/branch side.
interface instruction_fetch_if #(
  parameter int XLEN = 32
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;

  logic            instr_valid;
  logic            dec_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] instr_pc;
  logic [6:0]      opcode;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            fetch_fault;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, opcode, fetch_fault,
    input  imem_ack, imem_rdata, dec_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, opcode, fetch_fault,
    output imem_ack, imem_rdata, dec_ready, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, fetches words over req/ack and hands them to decode over valid/ready.
// Define IF_ALIGN_CHECK_EN to trap misaligned redirects into a sticky fault and the HALT state.
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic                 clk,
  input logic                 reset,
  instruction_fetch_if.master bus
);

  fetch_state_e    r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic [XLEN-1:0] r_pend_pc, w_pend_pc_nxt;
  logic [XLEN-1:0] r_instr_pc, w_instr_pc_nxt;
  logic [31:0]     r_instr, w_instr_nxt;
  logic            r_valid, w_valid_nxt;
  logic            r_fault, w_fault_nxt;

  logic [XLEN-1:0] w_pc_inc;
  logic [XLEN-1:0] w_redir_pc;
  logic            w_misaligned;
  logic            w_redirect;

  // Wraps modulo 2^XLEN; the low two bits stay zero because every PC source is word-aligned.
  assign w_pc_inc   = r_pc + XLEN'(4);
  assign w_redir_pc = {bus.redirect_pc[XLEN-1:2], 2'b00};

`ifdef IF_ALIGN_CHECK_EN
  assign w_misaligned = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_redirect = bus.redirect_valid && !w_misaligned;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_pend_pc_nxt  = r_pend_pc;
    w_instr_nxt    = r_instr;
    w_instr_pc_nxt = r_instr_pc;
    w_valid_nxt    = r_valid;
    w_fault_nxt    = r_fault | w_misaligned;

    unique case (r_state)
      S_REQ: begin
`ifdef IF_ALIGN_CHECK_EN
        if (w_misaligned) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = bus.imem_ack ? S_HALT : S_DRAIN;
        end else
`endif
        if (w_redirect) begin
          if (bus.imem_ack) begin
            w_pc_nxt = w_redir_pc;
          end else begin
            w_pend_pc_nxt = w_redir_pc;
            w_state_nxt   = S_DRAIN;
          end
        end else if (bus.imem_ack) begin
          w_instr_nxt    = bus.imem_rdata;
          w_instr_pc_nxt = r_pc;
          w_valid_nxt    = 1'b1;
          w_pc_nxt       = w_pc_inc;
          w_state_nxt    = S_HOLD;
        end
      end

      S_HOLD: begin
`ifdef IF_ALIGN_CHECK_EN
        if (w_misaligned) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = S_HALT;
        end else
`endif
        if (w_redirect) begin
          w_pc_nxt    = w_redir_pc;
          w_valid_nxt = 1'b0;
          w_state_nxt = S_REQ;
        end else if (bus.dec_ready) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = S_REQ;
        end
      end

      // The old request stays on the bus until acked; the redirect target waits in r_pend_pc.
      S_DRAIN: begin
        if (w_redirect) begin
          w_pend_pc_nxt = w_redir_pc;
        end
        if (bus.imem_ack) begin
          w_pc_nxt = w_pend_pc_nxt;
`ifdef IF_ALIGN_CHECK_EN
          w_state_nxt = w_fault_nxt ? S_HALT : S_REQ;
`else
          w_state_nxt = S_REQ;
`endif
        end
      end

`ifdef IF_ALIGN_CHECK_EN
      S_HALT: begin
        w_valid_nxt = 1'b0;
      end
`endif

      default: begin
        w_state_nxt = S_REQ;
      end
    endcase
  end

  // NOTE: reset is synchronous, so it lives inside the clocked block rather than in its sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_REQ;
      r_pc       <= RESET_PC;
      r_pend_pc  <= RESET_PC;
      r_instr    <= NOP_INSTR;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update on the same clock edge.
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_pend_pc  <= w_pend_pc_nxt;
      r_instr    <= w_instr_nxt;
      r_instr_pc <= w_instr_pc_nxt;
      r_valid    <= w_valid_nxt;
      r_fault    <= w_fault_nxt;
    end
  end

  // Request decoded from state so it is valid in the cycle the state is entered.
  assign bus.imem_req    = !reset && ((r_state == S_REQ) || (r_state == S_DRAIN));
  assign bus.imem_addr   = r_pc;
  assign bus.instr_valid = r_valid;
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.opcode      = r_valid ? r_instr[6:0] : 7'b0000000;
  assign bus.fetch_fault = r_fault;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: per-cycle vector table plus hand sequences for
// misaligned redirect, reset mid-transaction and PC wrap.
`timescale 1ns/1ps
module tb_instruction_fetch;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic reset_w;

  always #5 clk = ~clk;

  instruction_fetch_if #(.XLEN(32)) bus ();
  instruction_fetch_if #(.XLEN(32)) wbus ();

  instruction_fetch #(.XLEN(32), .RESET_PC(32'h0000_0000)) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  instruction_fetch #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk  (clk),
    .reset(reset_w),
    .bus  (wbus.master)
  );

  // Zero-wait memory and an always-ready decoder for the wrap instance.
  assign wbus.imem_ack       = wbus.imem_req;
  assign wbus.imem_rdata     = 32'h00A00093;
  assign wbus.dec_ready      = 1'b1;
  assign wbus.redirect_valid = 1'b0;
  assign wbus.redirect_pc    = 32'h0;

  localparam logic [31:0] I_A = 32'h00A00093; // addi  -> OPIMM
  localparam logic [31:0] I_B = 32'h00100113; // addi  -> OPIMM
  localparam logic [31:0] I_C = 32'h0000A183; // lw    -> LOAD
  localparam logic [31:0] I_D = 32'h0020A023; // sw    -> STORE
  localparam logic [31:0] I_E = 32'h002081B3; // add   -> OP

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_ipc;
    logic [31:0] e_instr;
    logic [6:0]  e_opc;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs[NVEC];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic ack, input logic [31:0] rdata, input logic rdy,
                       input logic redir, input logic [31:0] rpc);
    bus.imem_ack       = ack;
    bus.imem_rdata     = rdata;
    bus.dec_ready      = rdy;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
  endtask

  task automatic step(input logic ack, input logic [31:0] rdata, input logic rdy,
                      input logic redir, input logic [31:0] rpc);
    @(negedge clk);
    drive(ack, rdata, rdy, redir, rpc);
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          ack   rdata         rdy   redir rpc            req   addr           vld   ipc            instr  opc
    vecs[0]  = '{1'b1, I_A,          1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_0004, 1'b1, 32'h0000_0000, I_A, OPC_OPIMM};
    vecs[1]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0004, 1'b0, 32'h0000_0000, I_A, 7'h00};
    vecs[2]  = '{1'b1, I_B,          1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_0008, 1'b1, 32'h0000_0004, I_B, OPC_OPIMM};
    vecs[3]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0008, 1'b0, 32'h0000_0004, I_B, 7'h00};
    vecs[4]  = '{1'b1, I_C,          1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_000C, 1'b1, 32'h0000_0008, I_C, OPC_LOAD};
    vecs[5]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_000C, 1'b1, 32'h0000_0008, I_C, OPC_LOAD};
    vecs[6]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_000C, 1'b1, 32'h0000_0008, I_C, OPC_LOAD};
    vecs[7]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_000C, 1'b1, 32'h0000_0008, I_C, OPC_LOAD};
    vecs[8]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_000C, 1'b1, 32'h0000_0008, I_C, OPC_LOAD};
    vecs[9]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_000C, 1'b1, 32'h0000_0008, I_C, OPC_LOAD};
    vecs[10] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0100, 1'b0, 32'h0000_0008, I_C, 7'h00};
    vecs[11] = '{1'b1, I_D,          1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_0104, 1'b1, 32'h0000_0100, I_D, OPC_STORE};
    vecs[12] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0104, 1'b0, 32'h0000_0100, I_D, 7'h00};
    vecs[13] = '{1'b1, I_E,          1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0008, 1'b0, 32'h0000_0100, I_D, 7'h00};
    vecs[14] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0180, 1'b1, 32'h0000_0008, 1'b0, 32'h0000_0100, I_D, 7'h00};
    vecs[15] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0008, 1'b0, 32'h0000_0100, I_D, 7'h00};
    vecs[16] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0200, 1'b1, 32'h0000_0008, 1'b0, 32'h0000_0100, I_D, 7'h00};
    vecs[17] = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0200, 1'b0, 32'h0000_0100, I_D, 7'h00};
    vecs[18] = '{1'b1, I_E,          1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0204, 1'b1, 32'h0000_0200, I_E, OPC_OP};
    vecs[19] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0204, 1'b0, 32'h0000_0200, I_E, 7'h00};

    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    reset   = 1'b1;
    reset_w = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req",    32'(bus.imem_req),    32'd0);
    check("rst_valid",  32'(bus.instr_valid), 32'd0);
    check("rst_instr",  bus.instr,            NOP_INSTR);
    check("rst_ipc",    bus.instr_pc,         32'h0);
    check("rst_opcode", 32'(bus.opcode),      32'd0);
    check("rst_fault",  32'(bus.fetch_fault), 32'd0);

    @(negedge clk);
    reset = 1'b0;
    #1;
    check("first_req",  32'(bus.imem_req), 32'd1);
    check("first_addr", bus.imem_addr,      32'h0);

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].ack, vecs[i].rdata, vecs[i].rdy, vecs[i].redir, vecs[i].rpc);
      check($sformatf("v%0d_req", i),    32'(bus.imem_req),    32'(vecs[i].e_req));
      check($sformatf("v%0d_addr", i),   bus.imem_addr,        vecs[i].e_addr);
      check($sformatf("v%0d_valid", i),  32'(bus.instr_valid), 32'(vecs[i].e_valid));
      check($sformatf("v%0d_ipc", i),    bus.instr_pc,         vecs[i].e_ipc);
      check($sformatf("v%0d_instr", i),  bus.instr,            vecs[i].e_instr);
      check($sformatf("v%0d_opcode", i), 32'(bus.opcode),      32'(vecs[i].e_opc));
    end

`ifdef IF_ALIGN_CHECK_EN
    // Fetch 0x204 into HOLD, then redirect to a misaligned target.
    step(1'b1, I_A, 1'b0, 1'b0, 32'h0);
    check("al_hold_ipc", bus.instr_pc, 32'h0000_0204);
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0102);
    check("al_fault", 32'(bus.fetch_fault), 32'd1);
    check("al_valid", 32'(bus.instr_valid), 32'd0);
    check("al_req",   32'(bus.imem_req),    32'd0);
    check("al_opc",   32'(bus.opcode),      32'd0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 32'h0, 1'b1, (k == 2), 32'h0000_0400);
      check($sformatf("halt%0d_req", k),   32'(bus.imem_req),    32'd0);
      check($sformatf("halt%0d_fault", k), 32'(bus.fetch_fault), 32'd1);
    end
`else
    // Misaligned redirect while waiting for ack: low bits dropped, target 0x3FC.
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_03FF);
    check("mis_drain_addr", bus.imem_addr, 32'h0000_0204);
    check("mis_drain_req",  32'(bus.imem_req), 32'd1);
    step(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
    check("mis_addr",  bus.imem_addr,        32'h0000_03FC);
    check("mis_valid", 32'(bus.instr_valid), 32'd0);
    step(1'b1, I_B, 1'b1, 1'b0, 32'h0);
    check("mis_ipc",   bus.instr_pc,         32'h0000_03FC);
    check("mis_fault", 32'(bus.fetch_fault), 32'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check("mis_next_addr", bus.imem_addr, 32'h0000_0400);
`endif

    // Reset while a request is outstanding (or while halted).
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    #1;
    check("mid_rst_req", 32'(bus.imem_req), 32'd0);
    @(posedge clk);
    #1;
    check("mid_rst_valid", 32'(bus.instr_valid), 32'd0);
    check("mid_rst_fault", 32'(bus.fetch_fault), 32'd0);
    check("mid_rst_instr", bus.instr,            NOP_INSTR);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_req",  32'(bus.imem_req), 32'd1);
    check("post_rst_addr", bus.imem_addr,     32'h0);

    // PC wrap from 0xFFFF_FFFC with zero-wait memory.
    @(negedge clk);
    reset_w = 1'b0;
    #1;
    check("wrap_req0",  32'(wbus.imem_req), 32'd1);
    check("wrap_addr0", wbus.imem_addr,     32'hFFFF_FFFC);
    @(posedge clk);
    #1;
    check("wrap_valid0", 32'(wbus.instr_valid), 32'd1);
    check("wrap_ipc0",   wbus.instr_pc,         32'hFFFF_FFFC);
    @(posedge clk);
    #1;
    check("wrap_req1",  32'(wbus.imem_req), 32'd1);
    check("wrap_addr1", wbus.imem_addr,     32'h0);
    @(posedge clk);
    #1;
    check("wrap_valid1", 32'(wbus.instr_valid), 32'd1);
    check("wrap_ipc1",   wbus.instr_pc,         32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage directly upstream of the decode Controller in the RISC-V core. Holds the program counter and fetches 32-bit instruction words from instruction memory over a req/ack handshake. Presents each instruction to decode with a valid/ready handshake and drives `opcode`, which feeds the Controller's `Opcode` input. Accepts control-flow redirects and squashes any in-flight or held instruction.

## Interface
- `XLEN`, default 32: address and PC width.
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `imem_req` out 1: fetch request to instruction memory.
- `imem_addr` out XLEN: fetch address; stable while `imem_req` is high.
- `imem_ack` in 1: memory response; `imem_rdata` is valid in the same cycle.
- `imem_rdata` in 32: instruction word.
- `instr_valid` out 1: `instr`, `instr_pc` and `opcode` are valid for decode.
- `dec_ready` in 1: decode consumes the held instruction.
- `instr` out 32: held instruction word.
- `instr_pc` out XLEN: PC of `instr`.
- `opcode` out 7: equals `instr[6:0]` when `instr_valid`, otherwise 7'b0000000 (Controller default, all controls 0).
- `redirect_valid` in 1: load a new PC (branch or jump).
- `redirect_pc` in XLEN: redirect target.
- `fetch_fault` out 1: misaligned redirect flag; present only under `IF_ALIGN_CHECK_EN`.

## Operation
- **FSM states:** REQ, HOLD, DRAIN, plus HALT under the macro.
- **REQ:** `imem_req`=1, `imem_addr`=pc. Hold both until `imem_ack`.
  - On ack: latch `instr`<=`imem_rdata`, `instr_pc`<=pc, `instr_valid`<=1, pc<=pc+4, go to HOLD.
- **HOLD:** `imem_req`=0. Hold `instr` until `dec_ready`, then `instr_valid`<=0 and go to REQ.
- **Redirect** (`redirect_valid`=1) always wins over `dec_ready` and `imem_ack`:
  - In HOLD: pc<=`redirect_pc`, `instr_valid`<=0, go to REQ.
  - In REQ with `imem_ack`=1: discard the response, pc<=`redirect_pc`, stay in REQ.
  - In REQ with `imem_ack`=0: pc<=`redirect_pc`, go to DRAIN.
  - In DRAIN: pc<=`redirect_pc` (latest target wins), stay in DRAIN.
- **DRAIN:** keep `imem_req`=1 with the old address until `imem_ack`, discard the data, then go to REQ at the redirected pc. A request is never withdrawn before its ack.
- **PC arithmetic:** pc+4 is modulo 2^XLEN, so 32'hFFFF_FFFC wraps to 0. pc[1:0] is always 2'b00.

## Timing
- **Reset values:** state=REQ, pc=`RESET_PC`, `instr_valid`=0, `instr`=32'h0000_0013 (NOP), `instr_pc`=0, `opcode`=0, `fetch_fault`=0.
- `imem_req` is forced to 0 while `reset` is high. The first request goes out in the first cycle after reset deasserts.
- Reset mid-transaction abandons the outstanding request; the memory must tolerate this.
- `imem_req` and `imem_addr` are decoded from state and pc, so they are valid in the same cycle the state is entered.
- **Latency:** ack in cycle N → `instr_valid`=1 in cycle N+1.
- **Throughput:** with zero-wait memory and `dec_ready` tied high, one instruction every 2 cycles.
- `dec_ready` is ignored while `instr_valid`=0.

## Configuration
- **`IF_ALIGN_CHECK_EN` defined:** a redirect with `redirect_pc[1:0]`≠0 sets `fetch_fault`=1 (sticky until reset), clears `instr_valid` and enters HALT.
  - HALT: `imem_req`=0; only `reset` exits.
  - If a request is outstanding, it drains first (DRAIN), then enters HALT.
- **Not defined:** `redirect_pc[1:0]` is ignored (treated as 00), the HALT state does not exist, and `fetch_fault` is tied 0.

## Structure
- Shared package `riscv_pkg`:
  - opcode constants OPC_LOAD 7'b0000011, OPC_STORE 7'b0100011, OPC_OPIMM 7'b0010011, OPC_OP 7'b0110011.
  - NOP_INSTR 32'h0000_0013.
  - fetch-state enum.
- Single module, no sub-module. The PC register and incrementer are too small to split out.

## Test plan
- **Reset then fetch:** RESET_PC=0, imem returns 32'h00A00093 with 0 wait, `dec_ready`=1 → `instr_valid` pulses every 2 cycles, `instr_pc` 0,4,8, `opcode`=7'b0010011.
- **Backpressure:** `dec_ready`=0 for 5 cycles → `instr` and `instr_pc` held stable, `imem_req`=0 throughout, no pc advance.
- **Redirect in HOLD with `dec_ready`=1:** `redirect_pc`=0x100 → `instr_valid` drops next cycle, next `imem_addr`=0x100.
- **Redirect while waiting 3-cycle ack:** `imem_addr` stays 0x8 until ack, data discarded (no `instr_valid`), then fetch 0x200.
- **Wrap:** RESET_PC=32'hFFFF_FFFC → second fetch address 0.
- **With `IF_ALIGN_CHECK_EN`:** `redirect_pc`=0x102 → `fetch_fault`=1, `imem_req` stays 0 until reset.
